// File: rtl/ram_arb_pkg.sv
// Shared types and the round-robin pick function for the RAM port arbiter.
// Requesters are handled in a fixed MAX_REQ-wide space and narrowed by the users.
package ram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);
  localparam int DEF_AW  = 8;
  localparam int DEF_W   = 32;

  typedef logic [MAX_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Width of one packed request record {we, addr, wdata}.
  function automatic int req_fields_w(input int aw, input int w);
    return 1 + aw + w;
  endfunction

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_W-1:0]  wdata;
  } req_fields_t;

  // First asserted request searching prio, prio+1, ... modulo n; one-hot result.
  function automatic req_vec_t rr_pick(input req_vec_t req, input idx_t prio, input int n);
    req_vec_t pick;
    bit       found;
    int       idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(prio) + i) % n;
      if (i < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: request fields in, grant and read return out.
// Handshake: a requester holds req[i] with stable fields until gnt[i]; the access happens at
// that clock edge, and a read returns rdata with rvalid[i] high for exactly the next cycle.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 8,
  parameter int W       = 32
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_we;
  logic [NUM_REQ-1:0][AW-1:0] req_addr;
  logic [NUM_REQ-1:0][W-1:0]  req_wdata;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         rvalid;
  logic [W-1:0]               rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/Single_Port_RAM.sv
// Single-port RAM with a registered read; a read during a write returns the old word.
module Single_Port_RAM #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     write_en,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[address] <= write_data;
    read_data <= mem[address];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: one-hot grant from req, with the priority pointer held here.
// The pointer moves to one past the winner on every grant and holds when idle.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output idx_t               prio
);

  req_vec_t req_ext;
  req_vec_t pick;
  idx_t     gnt_idx;
  logic     gnt_any;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    pick                 = rr_pick(req_ext, prio, NUM_REQ);
    gnt_any              = |pick;
    gnt_idx              = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) gnt_idx = idx_t'(i);
    end
  end

  assign gnt = pick[NUM_REQ-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= '0;
    end else if (gnt_any) begin
      prio <= (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + idx_t'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters with round-robin arbitration.
// The granted requester's fields drive the RAM directly; reads return one cycle later.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WIDTH = 32,
  localparam int AW       = $clog2(MEM_DEPTH),
  localparam int W        = MEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     bus,
  output logic [AW-1:0]         ram_address,
  output logic [W-1:0]          ram_write_data,
  output logic                  ram_write_en,
  input  logic [W-1:0]          ram_read_data,
  output idx_t                  dbg_prio
);

  localparam int FW = req_fields_w(AW, W);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } fields_t;

  logic [NUM_REQ-1:0][FW-1:0] fields;
  fields_t                    sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .gnt   (bus.gnt),
    .prio  (dbg_prio)
  );

  // AND-OR mux on the one-hot grant, so an idle cycle drives all zeros.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fields[i] = {bus.req_we[i], bus.req_addr[i], bus.req_wdata[i]};
      if (bus.gnt[i]) sel = fields_t'(fields[i]);
    end
  end

  assign ram_address    = sel.addr;
  assign ram_write_data = sel.wdata;
  assign ram_write_en   = sel.we;
  assign bus.rdata      = ram_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.rvalid <= '0;
    else       bus.rvalid <= bus.gnt & ~bus.req_we;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one `Single_Port_RAM` instance (one address, one access per cycle, 1-cycle registered read) among `NUM_REQ` requesters, e.g. the matrix loader, the multiply engine and the result unloader. Each requester issues single-word reads or writes with a req/gnt handshake. The arbiter drives the RAM's address, write data and write enable, and returns read data with a per-requester valid strobe one cycle after the grant.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `MEM_DEPTH`, default 256: RAM depth in words. Address width `AW = $clog2(MEM_DEPTH)`.
- `MEM_WIDTH`, default 32: word width `W`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, NUM_REQ: request per requester. Held high, with its fields stable, until granted.
- `req_we`, in, NUM_REQ: per requester, 1 = write, 0 = read.
- `req_addr`, in, NUM_REQ×AW: word address per requester.
- `req_wdata`, in, NUM_REQ×W: write data per requester.
- `gnt`, out, NUM_REQ: one-hot grant, combinational. Access is performed at the edge where `gnt` is high.
- `rvalid`, out, NUM_REQ: one-hot, registered. Read data valid for the requester granted a read in the previous cycle.
- `rdata`, out, W: shared read data, a direct pass-through of `ram_read_data`.
- `ram_address`, out, AW: to the RAM address input.
- `ram_write_data`, out, W: to the RAM write-data input.
- `ram_write_en`, out, 1: to the RAM write enable.
- `ram_read_data`, in, W: from the RAM read data output.

## Operation
- Arbitration is round-robin using a registered pointer `prio`, the index of the highest-priority requester.
  - The winner is the first asserted `req[i]` searching `prio`, `prio+1`, …, wrapping modulo NUM_REQ.
  - On any grant to index `i`, `prio` is set to `(i+1) mod NUM_REQ`.
  - With no requests, `prio` holds.
- At most one `gnt` bit is high per cycle. With no requests, `gnt` is 0.
- RAM drive when a requester `i` is granted: `ram_address = req_addr[i]`, `ram_write_data = req_wdata[i]`, `ram_write_en = req_we[i]`.
- RAM drive when idle: `ram_address = 0`, `ram_write_data = 0`, `ram_write_en = 0`.
  - The RAM still performs a read of address 0, which is ignored.
- Read return: a granted read sets `rvalid[i]` for exactly the next cycle. A granted write produces no `rvalid`.
- Read-during-write: the RAM returns the old word. A write to A followed next cycle by a read of A returns the new word.
- A requester may keep `req` high after its grant to issue back-to-back accesses. Such a requester is then granted in alternation with any other pending requesters.
- A pending request is granted within NUM_REQ cycles (starvation-free).
- Dropping `req` before grant is legal and simply withdraws the request.
- Reset (asynchronous, at any time):
  - `prio` is set to 0 and the `rvalid` register is cleared.
  - An in-flight read is discarded: no `rvalid` is produced after reset release.

## Timing
- Values while `reset` is high or after reset:
  - `rvalid` = 0 and `prio` = 0.
  - `gnt`, `ram_*` and `rdata` are combinational. They follow inputs, with `prio` = 0.
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` if that requester wins.
- Read latency is 1 cycle from grant edge to `rvalid`/`rdata`.
- Throughput is one access per cycle in aggregate, with no bubble between a write and a read or between different requesters.
- The combinational path from `req` to `gnt` and `ram_*` goes through one priority-rotate stage. Requesters must register their outputs.

## Structure
- Package `ram_arb_pkg`:
  - `typedef` for the request fields (`we`, `addr`, `wdata`), parameterized via a localparam width helper.
  - Function `rr_pick(req, prio)` returning the one-hot winner.
  - Constant `MAX_REQ = 8`.
- Sub-module `rr_arbiter`: NUM_REQ-wide rotate-priority picker producing the one-hot grant plus the winner index, with the `prio` register inside.
- The top level contains the field mux, the RAM drive and the `rvalid` register.
- The bench instantiates `Single_Port_RAM` behind the arbiter.

## Test plan
- Single write then read: requester 0 writes 0xDEADBEEF to address 5, then reads address 5. Required: `gnt[0]` on both cycles, `rvalid[0]` one cycle after the read grant, `rdata` = 0xDEADBEEF.
- All three requesters hold `req` high continuously from reset with reads. Required: grants in the order 0,1,2,0,1,2; each `rvalid` is one-hot and matches the previous cycle's grant.
- Write/read hazard: requester 1 writes 0x11 to address 7 while requester 2 requests a read of address 7. Required: requester 1 is granted first (`prio` = 1 after a prior grant to 0), then requester 2 reads 0x11.
- Idle cycles: no requests for 5 cycles. Required: `gnt` = 0, `ram_write_en` = 0, `rvalid` = 0, and `prio` unchanged.
- Reset mid-read: assert `reset` in the cycle after a granted read. Required: `rvalid` is 0 immediately and stays 0 after release; the next grant goes to requester 0.
- Withdrawn request: requester 2 drops `req` before it is granted. Required: no grant and no `rvalid` for requester 2, and no write occurs to its address (verified by read-back of the old value).
